hack_fetch: RTL and testbench



---
 rtl/hack_pkg.sv | 19 +
 rtl/fetch_buf.sv | 82 ++++++++
 rtl/hack_fetch.sv | 137 +++++++++++++
 tb/tb_hack_fetch.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the hack fetch stage.
// Define HACK_FETCH_PREFETCH_EN for a 2-entry fetch buffer (default 1).
package hack_pkg;

    localparam int WORD_W = 16;

`ifdef HACK_FETCH_PREFETCH_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Small in-order buffer of {instr, pc} between fetch and decode.
// Head sits in slot 0; pops shift the younger entry forward.
module fetch_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] push_instr,
    input  logic [W-1:0] push_pc,
    output logic         valid,
    output logic [W-1:0] head_instr,
    output logic [W-1:0] head_pc,
    output logic         has_space
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  instr_q [DEPTH];
    logic [W-1:0]  instr_d [DEPTH];
    logic [W-1:0]  pc_q    [DEPTH];
    logic [W-1:0]  pc_d    [DEPTH];
    logic          pop_ok;

    assign valid      = (cnt_q != '0);
    assign pop_ok     = pop && valid;
    assign has_space  = (cnt_q < DEPTH_C) || pop_ok;
    assign head_instr = instr_q[0];
    assign head_pc    = pc_q[0];

    // Next contents: flush wins, else pop shifts, then push appends.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            instr_d[i] = instr_q[i];
            pc_d[i]    = pc_q[i];
        end
        if (flush) begin
            cnt_d = '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    instr_d[i] = instr_q[i+1];
                    pc_d[i]    = pc_q[i+1];
                end
                cnt_d = cnt_q - CW'(1);
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cnt_d == CW'(i)) begin
                        instr_d[i] = push_instr;
                        pc_d[i]    = push_pc;
                    end
                end
                cnt_d = cnt_d + CW'(1);
            end
        end
    end

    // Buffer storage and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= instr_d[i];
                pc_q[i]    <= pc_d[i];
            end
        end
    end

endmodule

// File: rtl/hack_fetch.sv
// Fetch stage: PC -> ROM req/ack -> buffer -> decode valid/ready.
// Buffer depth follows HACK_FETCH_PREFETCH_EN via hack_pkg::BUF_DEPTH.
module hack_fetch #(
    parameter int WORD_W = hack_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] pc_addr,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [WORD_W-1:0] pc_in,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_data,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_addr
);

    import hack_pkg::*;

    fetch_state_t      state_q, state_d;
    logic              req_q, req_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic              inc_q, inc_d;
    logic              load_q, load_d;
    logic [WORD_W-1:0] pcin_q, pcin_d;

    logic buf_push;
    logic buf_pop;
    logic buf_flush;
    logic buf_space;
    logic issue_ok;

    // Only issue once the PC has settled from any pending inc/load.
    assign issue_ok = buf_space && !redirect && !inc_q && !load_q;
    assign buf_pop  = instr_valid && instr_ready;

    // State and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            inc_q   <= 1'b0;
            load_q  <= 1'b0;
            pcin_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
            load_q  <= load_d;
            pcin_q  <= pcin_d;
        end
    end

    // Next state; an ack always ends the outstanding request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (issue_ok) state_d = WAIT;
            end
            WAIT: begin
                if (imem_ack)      state_d = IDLE;
                else if (redirect) state_d = DRAIN;
            end
            DRAIN: begin
                if (imem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and buffer controls; a redirect squashes any push.
    always_comb begin
        req_d     = req_q;
        addr_d    = addr_q;
        inc_d     = 1'b0;
        load_d    = redirect;
        pcin_d    = redirect ? redirect_addr : pcin_q;
        buf_push  = 1'b0;
        buf_flush = redirect;
        unique case (state_q)
            IDLE: begin
                if (issue_ok) begin
                    req_d  = 1'b1;
                    addr_d = pc_addr;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    req_d = 1'b0;
                    if (!redirect) begin
                        buf_push = 1'b1;
                        inc_d    = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (imem_ack) req_d = 1'b0;
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    fetch_buf #(
        .W     (WORD_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (buf_push),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .push_instr (imem_data),
        .push_pc    (addr_q),
        .valid      (instr_valid),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .has_space  (buf_space)
    );

    assign pc_inc    = inc_q;
    assign pc_load   = load_q;
    assign pc_in     = pcin_q;
    assign imem_req  = req_q;
    assign imem_addr = addr_q;

endmodule

// File: tb/tb_hack_fetch.sv
// Self-checking bench for hack_fetch: PC and ROM models plus an
// instruction-stream scoreboard, directed steps then random traffic.
module tb_hack_fetch;

`ifdef HACK_FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic [15:0] pc_addr;
    logic        pc_inc;
    logic        pc_load;
    logic [15:0] pc_in;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_addr;

    hack_fetch dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_addr       (pc_addr),
        .pc_inc        (pc_inc),
        .pc_load       (pc_load),
        .pc_in         (pc_in),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_inc = 0;
    int n_pop = 0;
    int hold_err = 0;
    int both_err = 0;
    int rom_lat = 1;
    int rom_cnt = 0;
    int cur_len = 0;
    int done_len = 0;
    logic [15:0] exp_pc = '0;

    logic [15:0] issue_addr[$];
    int          issue_cyc[$];
    int          issue_inc[$];
    logic [15:0] pop_pc_q[$];
    logic [15:0] pop_ins_q[$];

    logic        p_rst, p_inc, p_ld, p_req, p_ack;
    logic        p_v, p_rdy, p_rd;
    logic [15:0] p_lin, p_addr, p_head, p_hpc, p_rda;

    function automatic logic [15:0] rom(input logic [15:0] a);
        logic [31:0] m;
        m = a * 32'h0101;
        return m[15:0] ^ 16'h1234;
    endfunction

    function automatic logic [79:0] outs();
        return {12'd0, pc_inc, pc_load, pc_in, imem_req, imem_addr,
                instr_valid, instr, instr_pc};
    endfunction

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic clear_logs();
        issue_addr.delete();
        issue_cyc.delete();
        issue_inc.delete();
        pop_pc_q.delete();
        pop_ins_q.delete();
    endtask

    // One clock: sample before the edge, update models after it.
    task automatic tick();
        @(negedge clk);
        p_rst = reset_n;  p_inc = pc_inc;   p_ld = pc_load;
        p_lin = pc_in;    p_req = imem_req; p_addr = imem_addr;
        p_ack = imem_ack; p_v = instr_valid; p_rdy = instr_ready;
        p_head = instr;   p_hpc = instr_pc;
        p_rd = redirect;  p_rda = redirect_addr;
        @(posedge clk);
        #1;
        cyc++;
        redirect = 1'b0;
        if (!reset_n)  pc_addr = '0;
        else if (p_ld) pc_addr = p_lin;
        else if (p_inc) pc_addr = pc_addr + 16'd1;
        if (p_inc && p_ld) both_err++;
        if (p_rst && p_v && p_rdy) begin
            chk("pop_pc", p_hpc, exp_pc);
            chk("pop_instr", p_head, rom(exp_pc));
            pop_pc_q.push_back(p_hpc);
            pop_ins_q.push_back(p_head);
            exp_pc = exp_pc + 16'd1;
            n_pop++;
        end
        if (p_rst && p_rd) exp_pc = p_rda;
        if (p_rst && p_req && !p_ack &&
            (!imem_req || imem_addr !== p_addr)) hold_err++;
        if (p_rst && p_req && p_ack) done_len = cur_len;
        if (imem_req && (!p_req || p_ack)) begin
            issue_addr.push_back(imem_addr);
            issue_cyc.push_back(cyc);
            issue_inc.push_back(n_inc);
            cur_len = 1;
        end else if (imem_req) begin
            cur_len++;
        end
        if (pc_inc) n_inc++;
        if (!reset_n) begin
            imem_ack = 1'b0;
            rom_cnt  = 0;
        end else if (p_ack) begin
            imem_ack  = 1'b0;
            rom_cnt   = 0;
            imem_data = 16'($urandom);
        end else if (imem_req) begin
            rom_cnt++;
            if (rom_cnt >= rom_lat) begin
                imem_ack  = 1'b1;
                imem_data = rom(imem_addr);
            end
        end
    endtask

    task automatic hold_reset(input logic rdy);
        reset_n     = 1'b0;
        redirect    = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = rdy;
        tick();
        tick();
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        exp_pc  = '0;
        n_inc   = 0;
        n_pop   = 0;
        clear_logs();
    endtask

    initial begin
        logic        found;
        logic        last_rd;
        int          inc_at;
        int          pop_at;
        reset_n = 1'b0;  pc_addr = '0;   imem_ack = 1'b0;
        imem_data = '0;  instr_ready = 1'b1;
        redirect = 1'b0; redirect_addr = '0;
        #2;

        // Reset state
        hold_reset(1'b1);
        chk("reset_outs", outs(), '0);
        chk("reset_valid", instr_valid, 1'b0);
        release_reset();

        // Zero-wait ROM, decode always ready
        rom_lat = 1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            found = (issue_addr.size() >= 2);
        end
        chk("t1_timeout", found, 1'b1);
        chk("t1_addr0", issue_addr[0], 16'h0000);
        chk("t1_addr1", issue_addr[1], 16'h0001);
        chk("t1_gap", issue_cyc[1] - issue_cyc[0], 3);
        chk("t1_one_inc", issue_inc[1] - issue_inc[0], 1);
        chk("t1_req_len", done_len, 1);
        chk("t1_pop_instr", pop_ins_q[0], 16'h1234);
        chk("t1_pop_pc", pop_pc_q[0], 16'h0000);

        // ROM ack after 4 cycles
        rom_lat = 4;
        clear_logs();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = (issue_addr.size() >= 1) && (issue_inc[0] < n_inc);
        end
        chk("t2_timeout", found, 1'b1);
        tick();
        tick();
        chk("t2_req_len", done_len, 4);
        chk("t2_one_inc", n_inc - issue_inc[0], 1);
        chk("t2_hold", hold_err, 0);

        // Decode stalled for 10+ cycles
        rom_lat = 1;
        hold_reset(1'b0);
        release_reset();
        for (int k = 0; k < 12; k++) tick();
        chk("t3_fill", n_inc, DEPTH);
        chk("t3_issues", issue_addr.size(), DEPTH);
        chk("t3_no_req", imem_req, 1'b0);
        chk("t3_valid", instr_valid, 1'b1);
        chk("t3_head_pc", instr_pc, 16'h0000);
        chk("t3_head", instr, rom(16'h0000));
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("t3_drained", pop_pc_q.size() >= 2, 1'b1);
        chk("t3_order0", pop_pc_q[0], 16'h0000);
        chk("t3_order1", pop_pc_q[1], 16'h0001);

        // Redirect while a request to address 5 is outstanding
        rom_lat = 4;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            found = imem_req && (imem_addr == 16'h0005);
        end
        chk("t4_timeout", found, 1'b1);
        inc_at = n_inc;
        redirect = 1'b1;
        redirect_addr = 16'h0100;
        tick();
        chk("t4_load", pc_load, 1'b1);
        chk("t4_pc_in", pc_in, 16'h0100);
        chk("t4_valid", instr_valid, 1'b0);
        chk("t4_no_inc", pc_inc, 1'b0);
        chk("t4_req_held", imem_req, 1'b1);
        clear_logs();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick();
            found = (issue_addr.size() >= 1);
        end
        chk("t4_reissue", found, 1'b1);
        chk("t4_new_addr", issue_addr[0], 16'h0100);
        chk("t4_drain_inc", n_inc, inc_at);

        // Redirect coinciding with ack
        rom_lat = 3;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = imem_req && imem_ack;
        end
        chk("t5_timeout", found, 1'b1);
        inc_at = n_inc;
        redirect = 1'b1;
        redirect_addr = 16'h0200;
        tick();
        chk("t5_no_inc", pc_inc, 1'b0);
        chk("t5_load", pc_load, 1'b1);
        chk("t5_pc_in", pc_in, 16'h0200);
        chk("t5_req_drop", imem_req, 1'b0);
        chk("t5_valid", instr_valid, 1'b0);
        tick();
        chk("t5_wait_pc", imem_req, 1'b0);
        chk("t5_load_end", pc_load, 1'b0);
        tick();
        chk("t5_issue", imem_req, 1'b1);
        chk("t5_addr", imem_addr, 16'h0200);
        chk("t5_inc_cnt", n_inc, inc_at);

        // Random traffic against the stream scoreboard
        pop_at = n_pop;
        last_rd = 1'b0;
        for (int k = 0; k < 400; k++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            if (!imem_req) rom_lat = $urandom_range(1, 4);
            if (!last_rd && $urandom_range(0, 19) == 0) begin
                redirect = 1'b1;
                redirect_addr = 16'($urandom);
            end
            last_rd = redirect;
            tick();
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("rand_progress", (n_pop - pop_at) > 20, 1'b1);
        chk("rand_hold", hold_err, 0);
        chk("rand_excl", both_err, 0);

        // Reset in the middle of a request, then a stray ack
        rom_lat = 5;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = imem_req;
        end
        chk("t6_timeout", found, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_outs", outs(), '0);
        tick();
        tick();
        release_reset();
        imem_ack = 1'b1;
        tick();
        chk("t6_stray_valid", instr_valid, 1'b0);
        chk("t6_stray_inc", pc_inc, 1'b0);
        chk("t6_issue", imem_req, 1'b1);
        chk("t6_addr", imem_addr, 16'h0000);
        tick();
        chk("t6_stray_valid2", instr_valid, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        chk("t6_fetch", n_pop >= 1, 1'b1);
        chk("final_hold", hold_err, 0);
        chk("final_excl", both_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
